// File: rtl/ht_pkg.sv
// ht_pkg: shared opcodes, table uo_out bit indices and driver state encoding
package ht_pkg;
  localparam logic [1:0] NOP    = 2'b00;
  localparam logic [1:0] INSERT = 2'b01;
  localparam logic [1:0] LOOKUP = 2'b10;
  localparam logic [1:0] DELETE = 2'b11;
  localparam int BUSY = 0;
  localparam int DONE = 1;
  localparam int OK   = 2;
  localparam int FULL = 3;
  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_t;
endpackage

// File: rtl/ht_host_driver_if.sv
// ht_host_driver_if: host request/response bundle
// master = host side (drives req_*), slave = driver side (drives req_ready, rsp_*)
interface ht_host_driver_if #(parameter int KEY_W = 6);
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_op;
  logic [KEY_W-1:0] req_key;
  logic [7:0]       req_val;
  logic             rsp_valid;
  logic             rsp_ok;
  logic             rsp_full;
  logic             rsp_timeout;
  logic [7:0]       rsp_val;
  modport master (
    output req_valid, req_op, req_key, req_val,
    input  req_ready, rsp_valid, rsp_ok, rsp_full, rsp_timeout, rsp_val
  );
  modport slave (
    input  req_valid, req_op, req_key, req_val,
    output req_ready, rsp_valid, rsp_ok, rsp_full, rsp_timeout, rsp_val
  );
endinterface

// File: rtl/ht_timeout_ctr.sv
// ht_timeout_ctr: 8-bit WAIT cycle counter
// clr: force to 0, en: increment, expired: count has reached LIMIT-1
module ht_timeout_ctr #(
  parameter int LIMIT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);
  logic [7:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= cnt + 8'd1;
  assign expired = cnt == 8'(LIMIT - 1);
endmodule

// File: rtl/ht_host_driver.sv
// ht_host_driver: sequences one host command at a time into the hash-table core
// host: request/response handshake (slave modport)
// ht_ui/ht_uio_in: command and insert value to the table
// ht_uo/ht_uio_out: busy/done/ok/full status and lookup data from the table
module ht_host_driver
  import ht_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int KEY_W   = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  ht_host_driver_if.slave     host,
  output logic [7:0]          ht_ui,
  output logic [7:0]          ht_uio_in,
  input  logic [7:0]          ht_uo,
  input  logic [7:0]          ht_uio_out
);
  state_t           st;
  logic [1:0]       op_q;
  logic [KEY_W-1:0] key_q;
  logic [7:0]       val_q;
  logic             ok_q, full_q, to_q;
  logic [7:0]       rval_q;
  logic             expired;
  logic             unused_uo;
  // busy is informational only; a done in any WAIT cycle ends the command
  assign unused_uo = ^{ht_uo[7:4], ht_uo[BUSY]};
  ht_timeout_ctr #(.LIMIT(TIMEOUT)) u_ctr (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (st != ST_WAIT),
    .en      (st == ST_WAIT),
    .expired (expired)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st     <= ST_IDLE;
      op_q   <= '0;
      key_q  <= '0;
      val_q  <= '0;
      ok_q   <= 1'b0;
      full_q <= 1'b0;
      to_q   <= 1'b0;
      rval_q <= '0;
    end else
      case (st)
        ST_IDLE:
          if (host.req_valid) begin
            op_q  <= host.req_op;
            key_q <= host.req_key;
            val_q <= host.req_val;
            if (host.req_op == NOP) begin
              ok_q   <= 1'b0;
              full_q <= 1'b0;
              to_q   <= 1'b0;
              rval_q <= '0;
              st     <= ST_RESP;
            end else st <= ST_ISSUE;
          end
        ST_ISSUE: st <= ST_WAIT;
        ST_WAIT:
          if (ht_uo[DONE]) begin
            ok_q   <= ht_uo[OK];
            full_q <= ht_uo[FULL];
            to_q   <= 1'b0;
            rval_q <= op_q == LOOKUP ? ht_uio_out : 8'h00;
            st     <= ST_RESP;
          end else if (expired) begin
            ok_q   <= 1'b0;
            full_q <= 1'b0;
            to_q   <= 1'b1;
            rval_q <= '0;
            st     <= ST_RESP;
          end
        default: st <= ST_IDLE;
      endcase
  assign ht_ui            = {st == ST_ISSUE ? op_q : NOP, 6'(key_q)};
  assign ht_uio_in        = (st == ST_ISSUE && op_q != INSERT) ? 8'h00 : val_q;
  assign host.req_ready   = st == ST_IDLE;
  assign host.rsp_valid   = st == ST_RESP;
  assign host.rsp_ok      = ok_q;
  assign host.rsp_full    = full_q;
  assign host.rsp_timeout = to_q;
  assign host.rsp_val     = rval_q;
endmodule

// File: tb/tb_ht_host_driver.sv
// tb_ht_host_driver: directed self-checking bench for ht_host_driver
module tb_ht_host_driver;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] ht_ui, ht_uio_in;
  logic [7:0] ht_uo = 8'h00;
  logic [7:0] ht_uio_out = 8'h00;
  int         total = 0;
  int         passed = 0;
  int         lat;
  ht_host_driver_if #(.KEY_W(6)) hif ();
  ht_host_driver #(.TIMEOUT(16), .KEY_W(6)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .host       (hif.slave),
    .ht_ui      (ht_ui),
    .ht_uio_in  (ht_uio_in),
    .ht_uo      (ht_uo),
    .ht_uio_out (ht_uio_out)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  task automatic rsp(input string tag, input logic ok, input logic full, input logic to, input logic [7:0] val);
    chk({tag, "_ok"}, 32'(hif.rsp_ok), 32'(ok));
    chk({tag, "_full"}, 32'(hif.rsp_full), 32'(full));
    chk({tag, "_to"}, 32'(hif.rsp_timeout), 32'(to));
    chk({tag, "_val"}, 32'(hif.rsp_val), 32'(val));
  endtask
  // Issues one command; the table answers with uo in WAIT cycle done_at (-1: never).
  // lat returns the number of cycles from WAIT entry until rsp_valid is seen.
  task automatic run(input string tag, input logic [1:0] op, input logic [5:0] key, input logic [7:0] val,
                     input int done_at, input logic [7:0] uo, input logic [7:0] uio, output int n);
    hif.req_valid = 1'b1;
    hif.req_op = op;
    hif.req_key = key;
    hif.req_val = val;
    ht_uio_out = uio;
    ht_uo = 8'h00;
    chk({tag, "_ready"}, 32'(hif.req_ready), 32'd1);
    tick;
    hif.req_valid = 1'b0;
    chk({tag, "_issue_ui"}, 32'(ht_ui), 32'({op, key}));
    chk({tag, "_issue_uio"}, 32'(ht_uio_in), op == 2'b01 ? 32'(val) : 32'd0);
    chk({tag, "_issue_ready"}, 32'(hif.req_ready), 32'd0);
    tick;
    chk({tag, "_wait_ui"}, 32'(ht_ui), 32'({2'b00, key}));
    chk({tag, "_wait_uio"}, 32'(ht_uio_in), 32'(val));
    n = 0;
    while (!hif.rsp_valid && n < 40) begin
      ht_uo = n == done_at ? uo : 8'h00;
      tick;
      n++;
    end
    ht_uo = 8'h00;
    chk({tag, "_rsp_valid"}, 32'(hif.rsp_valid), 32'd1);
  endtask
  initial begin
    hif.req_valid = 1'b0;
    hif.req_op = 2'b00;
    hif.req_key = 6'h00;
    hif.req_val = 8'h00;
    repeat (2) tick;
    chk("rst_ready", 32'(hif.req_ready), 32'd1);
    chk("rst_valid", 32'(hif.rsp_valid), 32'd0);
    chk("rst_ui", 32'(ht_ui), 32'd0);
    chk("rst_uio", 32'(ht_uio_in), 32'd0);
    rsp("rst", 1'b0, 1'b0, 1'b0, 8'h00);
    rst_n = 1'b1;
    run("ins", 2'b01, 6'h05, 8'hA7, 2, 8'h06, 8'h00, lat);
    chk("ins_lat", 32'(lat), 32'd3);
    chk("ins_ui_resp", 32'(ht_ui), 32'h05);
    rsp("ins", 1'b1, 1'b0, 1'b0, 8'h00);
    tick;
    chk("ins_pulse", 32'(hif.rsp_valid), 32'd0);
    chk("ins_hold_ok", 32'(hif.rsp_ok), 32'd1);
    chk("ins_idle_ready", 32'(hif.req_ready), 32'd1);
    run("lkp", 2'b10, 6'h05, 8'h00, 1, 8'h06, 8'hA7, lat);
    chk("lkp_lat", 32'(lat), 32'd2);
    rsp("lkp", 1'b1, 1'b0, 1'b0, 8'hA7);
    tick;
    hif.req_valid = 1'b1;
    hif.req_op = 2'b00;
    hif.req_key = 6'h03;
    tick;
    hif.req_valid = 1'b0;
    chk("nop_valid", 32'(hif.rsp_valid), 32'd1);
    chk("nop_ui", 32'(ht_ui), 32'h03);
    rsp("nop", 1'b0, 1'b0, 1'b0, 8'h00);
    tick;
    run("full", 2'b01, 6'h09, 8'h11, 0, 8'h0B, 8'h00, lat);
    chk("full_lat", 32'(lat), 32'd1);
    rsp("full", 1'b0, 1'b1, 1'b0, 8'h00);
    tick;
    run("del", 2'b11, 6'h05, 8'h00, 0, 8'h07, 8'hFF, lat);
    chk("del_lat", 32'(lat), 32'd1);
    rsp("del", 1'b1, 1'b0, 1'b0, 8'h00);
    tick;
    ht_uo = 8'h06;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("idle_done_valid", 32'(hif.rsp_valid), 32'd0);
      chk("idle_done_ready", 32'(hif.req_ready), 32'd1);
    end
    ht_uo = 8'h00;
    run("tmo", 2'b10, 6'h07, 8'h00, -1, 8'h00, 8'hFF, lat);
    chk("tmo_lat", 32'(lat), 32'd16);
    rsp("tmo", 1'b0, 1'b0, 1'b1, 8'h00);
    tick;
    run("edge", 2'b10, 6'h07, 8'h00, 15, 8'h06, 8'h3C, lat);
    chk("edge_lat", 32'(lat), 32'd16);
    rsp("edge", 1'b1, 1'b0, 1'b0, 8'h3C);
    tick;
    hif.req_valid = 1'b1;
    hif.req_op = 2'b01;
    hif.req_key = 6'h0A;
    hif.req_val = 8'h33;
    tick;
    hif.req_valid = 1'b0;
    tick;
    tick;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ready", 32'(hif.req_ready), 32'd1);
    chk("arst_valid", 32'(hif.rsp_valid), 32'd0);
    chk("arst_ui", 32'(ht_ui), 32'd0);
    chk("arst_uio", 32'(ht_uio_in), 32'd0);
    rsp("arst", 1'b0, 1'b0, 1'b0, 8'h00);
    repeat (2) begin
      tick;
      chk("arst_hold_valid", 32'(hif.rsp_valid), 32'd0);
    end
    rst_n = 1'b1;
    run("post", 2'b10, 6'h0A, 8'h00, 0, 8'h06, 8'h5A, lat);
    chk("post_lat", 32'(lat), 32'd1);
    rsp("post", 1'b1, 1'b0, 1'b0, 8'h5A);
    tick;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
